// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM packet path: flit tags, field positions,
// transmit FSM states and the response request record.
package lcm_pkg;

  localparam int FLIT_W   = 134;
  localparam int TAG_HI   = 133;
  localparam int TAG_LO   = 132;
  localparam int REG_N_HI = 127;
  localparam int REG_N_LO = 120;
  localparam int VALUE_HI = 119;
  localparam int VALUE_LO = 56;
  localparam int RD_BIT   = 48;

  localparam logic [1:0] LCM_HEAD = 2'b01;
  localparam logic [1:0] LCM_MID  = 2'b11;
  localparam logic [1:0] LCM_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_MID,
    ST_TAIL
  } lcm_state_e;

  typedef struct packed {
    logic        is_rd;
    logic [7:0]  reg_n;
    logic [63:0] value;
  } lcm_rsp_req_t;

  // Flit emitted while in state st; IDLE yields an all-zero bus.
  function automatic logic [FLIT_W-1:0] lcm_build_flit(input lcm_state_e st,
                                                       input logic [7:0] lmid,
                                                       input lcm_rsp_req_t req);
    logic [FLIT_W-1:0] f;
    f = '0;
    case (st)
      ST_HEAD: begin
        f[TAG_HI:TAG_LO]     = LCM_HEAD;
        f[REG_N_HI:REG_N_LO] = lmid;
        f[RD_BIT]            = req.is_rd;
      end
      ST_MID:  f[TAG_HI:TAG_LO] = LCM_MID;
      ST_TAIL: begin
        f[TAG_HI:TAG_LO]     = LCM_TAIL;
        f[REG_N_HI:REG_N_LO] = req.reg_n;
        // write acks carry no payload
        f[VALUE_HI:VALUE_LO] = req.is_rd ? req.value : 64'd0;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lcm_rsp_hold.sv
// One-entry request holding register with saturating drop counter.
// A pop and a push in the same cycle refill the freed slot.
module lcm_rsp_hold
  import lcm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  lcm_rsp_req_t push_req,
  input  logic         pop,
  output logic         full,
  output lcm_rsp_req_t req,
  output logic [15:0]  drop_cnt
);

  // Slot occupancy, contents and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full     <= 1'b0;
      req      <= '0;
      drop_cnt <= 16'd0;
    end else begin
      if (push && (!full || pop)) begin
        full <= 1'b1;
        req  <= push_req;
      end else if (pop) begin
        full <= 1'b0;
      end
      if (push && full && !pop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/lcm_rsp_builder.sv
// LCM response builder: serialises register read results / write acks into
// head, MID_FLITS middle and tail flits on the 134-bit packet bus.
module lcm_rsp_builder
  import lcm_pkg::*;
#(
  parameter string      PLATFORM  = "Xilinx-OpenBox-S4",
  parameter logic [7:0] LMID      = 8'd3,
  parameter logic [3:0] MID_FLITS = 4'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rsp_req_valid,
  input  logic         rsp_req_is_rd,
  input  logic [7:0]   rsp_req_reg_n,
  input  logic [63:0]  rsp_req_value,
  output logic [133:0] out_lcm_data,
  output logic         out_lcm_data_wr,
  output logic         out_lcm_data_valid,
  output logic         out_lcm_data_valid_wr,
  input  logic         out_lcm_data_ready,
  output logic         rsp_busy,
  output logic [15:0]  rsp_drop_cnt
);

  localparam logic [3:0] MID_LAST = MID_FLITS - 4'd1;

  lcm_state_e   state, state_nxt;
  logic [3:0]   mid_cnt, mid_cnt_nxt;
  lcm_rsp_req_t cur_req, live_req, hold_req, sel_req;
  logic         hold_full, launch, pop, push;

  assign live_req = '{is_rd: rsp_req_is_rd, reg_n: rsp_req_reg_n, value: rsp_req_value};

  // Ready is only looked at in IDLE; the held request wins over the live one.
  assign launch  = (state == ST_IDLE) && out_lcm_data_ready && (hold_full || rsp_req_valid);
  assign pop     = launch && hold_full;
  assign push    = rsp_req_valid && !(launch && !hold_full);
  assign sel_req = hold_full ? hold_req : live_req;

  lcm_rsp_hold u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (live_req),
    .pop      (pop),
    .full     (hold_full),
    .req      (hold_req),
    .drop_cnt (rsp_drop_cnt)
  );

  // Next-state and middle-flit counter.
  always_comb begin
    state_nxt   = state;
    mid_cnt_nxt = mid_cnt;
    case (state)
      ST_IDLE: if (launch) state_nxt = ST_HEAD;
      ST_HEAD: begin
        mid_cnt_nxt = 4'd0;
        state_nxt   = (MID_FLITS != 4'd0) ? ST_MID : ST_TAIL;
      end
      ST_MID: begin
        if (mid_cnt == MID_LAST) state_nxt = ST_TAIL;
        else                     mid_cnt_nxt = mid_cnt + 4'd1;
      end
      ST_TAIL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request and registered flit outputs (driven from next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      mid_cnt               <= 4'd0;
      cur_req               <= '0;
      out_lcm_data          <= '0;
      out_lcm_data_wr       <= 1'b0;
      out_lcm_data_valid    <= 1'b0;
      out_lcm_data_valid_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      mid_cnt <= mid_cnt_nxt;
      if (launch) cur_req <= sel_req;
      out_lcm_data          <= lcm_build_flit(state_nxt, LMID, launch ? sel_req : cur_req);
      out_lcm_data_wr       <= (state_nxt != ST_IDLE);
      out_lcm_data_valid    <= (state_nxt == ST_TAIL);
      out_lcm_data_valid_wr <= (state_nxt == ST_TAIL);
    end
  end

  assign rsp_busy = (state != ST_IDLE) || hold_full;

endmodule
